timer_1us_tick: RTL and testbench
=================================

// Module: timer_1us_tick
// PURPOSE
//  - Periodic tick generator timed in microseconds from the 36 MHz system clock.
//  - Emits a one-cycle pulse on q every PERIOD_US microseconds, i.e. every
//    CYCLES_PER_US*PERIOD_US enabled clocks.
//  - Paces game logic, e.g. invader movement (PERIOD_US=100000) and a fast
//    auxiliary tick (PERIOD_US=2000).
// PARAMETERS
//  - PERIOD_US      default 1       tick period in us. First positional parameter,
//                                   so #(N) sets it. Legal range 1..2^32-1; 0 behaves as 1.
//  - CYCLES_PER_US  default 36      clocks per microsecond (36 MHz clock).
// PORTS
//  - clk_36MHz  in   1  system clock, 36 MHz; all logic on its rising edge.
//  - reset      in   1  synchronous, active-low reset (0 = reset).
//  - en         in   1  count enable; 1 = run, 0 = freeze all counters.
//  - q          out  1  registered tick; high for exactly one clock per period.
// BEHAVIOUR
//  - Reset (reset==0 at a rising edge):
//    - prescaler <= 0, period counter <= 0, q <= 0.
//    - Reset has priority over en.
//    - Reset mid-count discards all progress; the next period starts from zero.
//  - Prescaler: pre counts 0..CYCLES_PER_US-1 on enabled cycles.
//    - When en && pre==CYCLES_PER_US-1: pre <= 0 and us_strobe=1 (combinational)
//      in that cycle.
//  - Period counter: cnt counts us_strobes 0..PERIOD_US-1.
//    - When us_strobe && cnt==PERIOD_US-1: cnt <= 0 and q <= 1.
//    - Otherwise q <= 0.
//  - Timing, with en held 1 and the first edge after reset release numbered edge 1:
//    - q goes high after edge CYCLES_PER_US*PERIOD_US and stays high one cycle.
//    - Repeats exactly every CYCLES_PER_US*PERIOD_US edges, with no drift.
//  - en==0:
//    - pre and cnt hold their values.
//    - q <= 0, so a tick is never issued while disabled.
//    - On re-enable, counting resumes where it stopped; total enabled cycles per
//      period are unchanged.
//  - Widths:
//    - pre is $clog2(CYCLES_PER_US) bits.
//    - cnt is max(1,$clog2(PERIOD_US)) bits.
//    - The compare uses full-width constants, so no wrap-around before the
//      terminal count.
//  - PERIOD_US==1: a tick on every us_strobe; cnt stays 0.
//  - No combinational path from any input to q.
//  - Power-up initial values match reset (pre=0, cnt=0, q=0) for FPGA targets.
// STRUCTURE
//  - Shared package timing_pkg:
//    - localparam CLK_HZ = 36_000_000
//    - localparam CYCLES_PER_US = CLK_HZ/1_000_000
//  - Sub-module us_prescaler (clk_36MHz, reset, en -> us_strobe) holds the
//    divide-by-CYCLES_PER_US counter.
//  - The period counter and q register live in the top.
// TESTING
//  - PERIOD_US=1, en=1 after reset release
//    -> q high only in cycles after edges 36, 72, 108; low elsewhere.
//  - PERIOD_US=2000, en=1
//    -> first q after edge 72000, next after edge 144000; pulse width 1 cycle.
//  - PERIOD_US=2, en dropped for 10 cycles at edge 40
//    -> first q after edge 82; q=0 throughout the en=0 window.
//  - PERIOD_US=2, reset pulled low for 1 cycle at edge 50
//    -> q=0; next q exactly 72 enabled edges after reset release.
//  - reset held low with en=1 for 100 cycles -> q stays 0, counters stay 0.
//  - Over 10 periods (PERIOD_US=3): the count of q pulses equals 10 and the
//    spacing is exactly 108 cycles.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared timing constants and width helpers for the 36 MHz clock domain.
package timing_pkg;

    localparam int unsigned CLK_HZ        = 36_000_000;
    localparam int unsigned CYCLES_PER_US = CLK_HZ / 1_000_000;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/timer_1us_tick_us_prescaler.sv
// Divide-by-CYCLES prescaler: one-cycle combinational strobe per microsecond.
module us_prescaler
    import timing_pkg::*;
#(
    parameter int unsigned CYCLES = timing_pkg::CYCLES_PER_US
) (
    input  logic clk_36MHz,
    input  logic reset,
    input  logic en,
    output logic us_strobe
);

    localparam int unsigned CYC_EFF = (CYCLES == 32'd0) ? 32'd1 : CYCLES;
    localparam int unsigned PRE_W   = width_of(CYC_EFF);
    localparam int unsigned PRE_END = CYC_EFF - 32'd1;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // Advance on enabled cycles; wrap and strobe at the last count.
    always_comb begin
        pre_d     = pre_q;
        us_strobe = 1'b0;
        if (en) begin
            if (32'(pre_q) == PRE_END) begin
                pre_d     = '0;
                us_strobe = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Prescaler register, synchronous active-low reset.
    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/timer_1us_tick.sv
// Periodic tick: one-cycle pulse on q every PERIOD_US microseconds of enabled time.
module timer_1us_tick
    import timing_pkg::*;
#(
    parameter int unsigned PERIOD_US     = 1,
    parameter int unsigned CYCLES_PER_US = timing_pkg::CYCLES_PER_US
) (
    input  logic clk_36MHz,
    input  logic reset,
    input  logic en,
    output logic q
);

    // A period of zero is treated as one microsecond.
    localparam int unsigned PERIOD_EFF = (PERIOD_US == 32'd0) ? 32'd1 : PERIOD_US;
    localparam int unsigned CNT_W      = width_of(PERIOD_EFF);
    localparam int unsigned CNT_END    = PERIOD_EFF - 32'd1;

    logic             us_strobe;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    us_prescaler #(
        .CYCLES    (CYCLES_PER_US)
    ) u_prescaler (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .en        (en),
        .us_strobe (us_strobe)
    );

    // Count microsecond strobes; terminal compare is done at full 32-bit width.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (us_strobe) begin
            if (32'(cnt_q) == CNT_END) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Period counter and tick register; reset wins over enable.
    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign q = tick_q;

endmodule

// File: tb/tb_timer_1us_tick.sv
// Bench for timer_1us_tick: several period settings against an enabled-cycle model.
module tb_timer_1us_tick;

    localparam int unsigned CPU = 36;
    localparam int          NI  = 4;
    localparam int unsigned PER [NI] = '{1, 2, 3, 0};

    logic          clk_36MHz = 1'b0;
    logic          reset     = 1'b0;
    logic          en        = 1'b0;
    logic [NI-1:0] dut_q;
    logic [NI-1:0] exp_q     = '0;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint en_cnt   = 0;
    int     edge_rel = 0;

    // Edge numbers (counted from reset release) at which each instance ticked.
    int pq0[$];
    int pq1[$];
    int pq2[$];
    int pq3[$];

    timer_1us_tick #(1) u_p1 (.clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(dut_q[0]));
    timer_1us_tick #(2) u_p2 (.clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(dut_q[1]));
    timer_1us_tick #(3) u_p3 (.clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(dut_q[2]));
    timer_1us_tick #(0) u_p0 (.clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(dut_q[3]));

    always #14 clk_36MHz = ~clk_36MHz;

    function automatic longint eff(input int unsigned p);
        return (p == 0) ? 64'd1 : longint'(p);
    endfunction

    function automatic int at_or(input int qq[$], input int i);
        return (i < qq.size()) ? qq[i] : -1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a tick follows every enabled edge whose running enabled-edge total
    // since reset is a multiple of CPU*period.
    always @(posedge clk_36MHz) begin
        if (!reset) begin
            en_cnt   = 0;
            edge_rel = 0;
            exp_q    = '0;
        end else begin
            edge_rel++;
            if (en) begin
                en_cnt++;
                for (int k = 0; k < NI; k++)
                    exp_q[k] = ((en_cnt % (longint'(CPU) * eff(PER[k]))) == 0);
            end else begin
                exp_q = '0;
            end
        end
    end

    // Per-cycle compare on the falling edge, plus tick-position logging.
    always @(negedge clk_36MHz) begin
        for (int k = 0; k < NI; k++)
            chk($sformatf("q[P=%0d]", PER[k]), longint'(dut_q[k]), longint'(exp_q[k]));
        if (dut_q[0]) pq0.push_back(edge_rel);
        if (dut_q[1]) pq1.push_back(edge_rel);
        if (dut_q[2]) pq2.push_back(edge_rel);
        if (dut_q[3]) pq3.push_back(edge_rel);
    end

    task automatic run_edges(input int n);
        repeat (n) @(negedge clk_36MHz);
    endtask

    task automatic clear_q();
        pq0.delete();
        pq1.delete();
        pq2.delete();
        pq3.delete();
    endtask

    // Apply a reset of n edges, then release with en=1.
    task automatic restart(input int n);
        reset = 1'b0;
        run_edges(n);
        clear_q();
        en    = 1'b1;
        reset = 1'b1;
    endtask

    initial begin
        // Reset held with en=1: no ticks at all.
        en    = 1'b1;
        reset = 1'b0;
        run_edges(100);
        chk("hold_pulses", longint'(pq0.size() + pq1.size() + pq2.size() + pq3.size()), 0);

        // Free run from a clean reset.
        clear_q();
        reset = 1'b1;
        run_edges(120);
        chk("p1_count",  pq0.size(), 3);
        chk("p1_tick0",  at_or(pq0, 0), 36);
        chk("p1_tick1",  at_or(pq0, 1), 72);
        chk("p1_tick2",  at_or(pq0, 2), 108);
        chk("p0_tick0",  at_or(pq3, 0), 36);
        chk("p2_tick0",  at_or(pq1, 0), 72);
        chk("p3_tick0",  at_or(pq2, 0), 108);

        // en dropped for 10 cycles after edge 40.
        restart(1);
        run_edges(40);
        en = 1'b0;
        run_edges(10);
        en = 1'b1;
        run_edges(60);
        chk("en_p2_tick0", at_or(pq1, 0), 82);
        chk("en_p2_count", pq1.size(), 1);
        chk("en_p1_tick1", at_or(pq0, 1), 82);

        // One-cycle reset at edge 50 discards progress.
        restart(1);
        run_edges(50);
        reset = 1'b0;
        run_edges(1);
        chk("rst_p2_none", pq1.size(), 0);
        clear_q();
        reset = 1'b1;
        run_edges(80);
        chk("rst_p2_tick0", at_or(pq1, 0), 72);

        // Ten periods of PERIOD_US=3.
        restart(1);
        run_edges(1090);
        chk("p3_count10", pq2.size(), 10);
        chk("p3_first", at_or(pq2, 0), 108);
        for (int i = 1; i < 10; i++)
            chk($sformatf("p3_space%0d", i), at_or(pq2, i) - at_or(pq2, i - 1), 108);

        // Randomized bursts of en and occasional resets, checked each cycle.
        repeat (400) begin
            reset = ($urandom_range(0, 24) != 0);
            en    = ($urandom_range(0, 9) < 8);
            run_edges(int'($urandom_range(1, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
